// File: rtl/complex_deinterleave_pkg.sv
// Shared definitions for the complex/real sample interleave pair.
package complex_deinterleave_pkg;

  localparam int unsigned DEF_CHANNEL_WIDTH = 16;
  localparam int unsigned DEF_CHANNELS      = 8;

  // Position of each component inside one complex slot, in units of CHANNEL_WIDTH.
  localparam int unsigned RE_SLOT = 0;
  localparam int unsigned IM_SLOT = 1;

  function automatic int unsigned complex_width(input int unsigned cw);
    return 2 * cw;
  endfunction

  function automatic int unsigned in_width(input int unsigned cw, input int unsigned ch);
    return complex_width(cw) * ch;
  endfunction

  function automatic int unsigned out_width(input int unsigned cw, input int unsigned ch);
    return cw * ch;
  endfunction

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer carrying data and last; fully registered.
module axis_skid_buffer
  import complex_deinterleave_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i
);

  skid_state_e           state_q, state_d;
  logic                  s_ready_q;
  logic [DATA_WIDTH-1:0] out_data_q, skid_data_q;
  logic                  out_last_q, skid_last_q;
  logic                  accept, emit;
  logic                  load_out_in, load_out_skid, load_skid;

  assign accept = s_valid_i & s_ready_q;
  assign emit   = (state_q != SKID_EMPTY) & m_ready_i;

  // State register; ready is taken from the next state so it never depends on m_ready_i combinationally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= SKID_EMPTY;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d != SKID_FULL);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SKID_EMPTY: if (accept) state_d = SKID_ONE;
      SKID_ONE: begin
        if (accept && !emit)      state_d = SKID_FULL;
        else if (emit && !accept) state_d = SKID_EMPTY;
      end
      SKID_FULL:  if (emit) state_d = SKID_ONE;
      default:    state_d = SKID_EMPTY;
    endcase
  end

  // Output flags and register load enables
  always_comb begin
    m_valid_o     = (state_q != SKID_EMPTY);
    s_ready_o     = s_ready_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    unique case (state_q)
      SKID_EMPTY: load_out_in = accept;
      SKID_ONE: begin
        load_out_in = accept & emit;
        load_skid   = accept & ~emit;
      end
      SKID_FULL:  load_out_skid = emit;
      default: ;
    endcase
  end

  // Output and skid data registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
    end else begin
      if (load_out_in) begin
        out_data_q <= s_data_i;
        out_last_q <= s_last_i;
      end else if (load_out_skid) begin
        out_data_q <= skid_data_q;
        out_last_q <= skid_last_q;
      end
      if (load_skid) begin
        skid_data_q <= s_data_i;
        skid_last_q <= s_last_i;
      end
    end
  end

  assign m_data_o = out_data_q;
  assign m_last_o = out_last_q;

endmodule

// File: rtl/complex_deinterleave.sv
// Complex-to-real deinterleaver: keeps real parts with optional rounding shift,
// flags residual imaginary energy, and counts output beats.
module complex_deinterleave
  import complex_deinterleave_pkg::*;
#(
  parameter  int unsigned CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
  parameter  int unsigned CHANNELS      = DEF_CHANNELS,
  parameter  int unsigned SHIFT         = 0,
  parameter  int unsigned IMAG_TOL      = 0,
  localparam int unsigned COMPLEX_WIDTH = complex_width(CHANNEL_WIDTH),
  localparam int unsigned IN_WIDTH      = in_width(CHANNEL_WIDTH, CHANNELS),
  localparam int unsigned OUT_WIDTH     = out_width(CHANNEL_WIDTH, CHANNELS)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [IN_WIDTH-1:0]  s_axis_complex_tdata,
  input  logic                 s_axis_complex_tvalid,
  output logic                 s_axis_complex_tready,
  input  logic                 s_axis_complex_tlast,
  output logic [OUT_WIDTH-1:0] m_axis_simple_tdata,
  output logic                 m_axis_simple_tvalid,
  input  logic                 m_axis_simple_tready,
  output logic                 m_axis_simple_tlast,
  output logic                 imag_err,
  input  logic                 imag_err_clr,
  output logic [31:0]          beat_count
);

  localparam int unsigned RE_LSB = RE_SLOT * CHANNEL_WIDTH;
  localparam int unsigned IM_LSB = IM_SLOT * CHANNEL_WIDTH;
  localparam logic signed [CHANNEL_WIDTH:0] ROUND =
    (SHIFT == 0) ? '0 : (CHANNEL_WIDTH+1)'(1 << (SHIFT - 1));
  localparam logic [CHANNEL_WIDTH:0] TOL = {1'b0, CHANNEL_WIDTH'(IMAG_TOL)};

  logic [OUT_WIDTH-1:0]          real_beat;
  logic                          imag_viol;
  logic signed [CHANNEL_WIDTH-1:0] re_raw, im_raw;
  logic signed [CHANNEL_WIDTH:0] re_ext, im_ext;
  logic [CHANNEL_WIDTH:0]        im_mag;
  logic                          in_hs, out_hs;
  logic                          imag_err_q, imag_err_d;
  logic [31:0]                   beat_count_q, beat_count_d;

  // Per-channel real extraction with round-half-up shift, and |imag| tolerance check
  always_comb begin
    real_beat = '0;
    imag_viol = 1'b0;
    re_raw    = '0;
    im_raw    = '0;
    re_ext    = '0;
    im_ext    = '0;
    im_mag    = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      re_raw = s_axis_complex_tdata[c*COMPLEX_WIDTH + RE_LSB +: CHANNEL_WIDTH];
      im_raw = s_axis_complex_tdata[c*COMPLEX_WIDTH + IM_LSB +: CHANNEL_WIDTH];
      re_ext = re_raw;
      im_ext = im_raw;
      // One extra bit keeps the rounding add and |most-negative| from overflowing.
      real_beat[c*CHANNEL_WIDTH +: CHANNEL_WIDTH] = CHANNEL_WIDTH'((re_ext + ROUND) >>> SHIFT);
      im_mag = im_ext[CHANNEL_WIDTH] ? -im_ext : im_ext;
      if (im_mag > TOL) imag_viol = 1'b1;
    end
  end

  axis_skid_buffer #(
    .DATA_WIDTH(OUT_WIDTH)
  ) u_skid (
    .clk_i     (aclk),
    .rst_ni    (aresetn),
    .s_data_i  (real_beat),
    .s_last_i  (s_axis_complex_tlast),
    .s_valid_i (s_axis_complex_tvalid),
    .s_ready_o (s_axis_complex_tready),
    .m_data_o  (m_axis_simple_tdata),
    .m_last_o  (m_axis_simple_tlast),
    .m_valid_o (m_axis_simple_tvalid),
    .m_ready_i (m_axis_simple_tready)
  );

  assign in_hs  = s_axis_complex_tvalid & s_axis_complex_tready;
  assign out_hs = m_axis_simple_tvalid & m_axis_simple_tready;

  // A new violation takes priority over a simultaneous clear.
  assign imag_err_d   = (in_hs & imag_viol) ? 1'b1 : (imag_err_clr ? 1'b0 : imag_err_q);
  assign beat_count_d = beat_count_q + 32'd1;

  // Sticky imag flag and wrapping output-beat counter
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      imag_err_q   <= 1'b0;
      beat_count_q <= '0;
    end else begin
      imag_err_q <= imag_err_d;
      if (out_hs) beat_count_q <= beat_count_d;
    end
  end

  assign imag_err   = imag_err_q;
  assign beat_count = beat_count_q;

endmodule

// File: tb/tb_complex_deinterleave.sv
// Directed bench for complex_deinterleave: two instances (SHIFT=0/TOL=2 and SHIFT=4/TOL=0) share stimulus.
module tb_complex_deinterleave;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [255:0] s_tdata;
  logic         s_tvalid, s_tlast, m_tready, clr;
  logic         s_tready0, s_tready1, m_tvalid0, m_tvalid1, m_tlast0, m_tlast1, ierr0, ierr1;
  logic [127:0] m_tdata0, m_tdata1;
  logic [31:0]  bc0, bc1;
  int           vectors = 0;
  int           miscompares = 0;

  always #5 aclk = ~aclk;

  complex_deinterleave #(.CHANNEL_WIDTH(16), .CHANNELS(8), .SHIFT(0), .IMAG_TOL(2)) dut0 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_complex_tdata(s_tdata), .s_axis_complex_tvalid(s_tvalid),
    .s_axis_complex_tready(s_tready0), .s_axis_complex_tlast(s_tlast),
    .m_axis_simple_tdata(m_tdata0), .m_axis_simple_tvalid(m_tvalid0),
    .m_axis_simple_tready(m_tready), .m_axis_simple_tlast(m_tlast0),
    .imag_err(ierr0), .imag_err_clr(clr), .beat_count(bc0)
  );

  complex_deinterleave #(.CHANNEL_WIDTH(16), .CHANNELS(8), .SHIFT(4), .IMAG_TOL(0)) dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_complex_tdata(s_tdata), .s_axis_complex_tvalid(s_tvalid),
    .s_axis_complex_tready(s_tready1), .s_axis_complex_tlast(s_tlast),
    .m_axis_simple_tdata(m_tdata1), .m_axis_simple_tvalid(m_tvalid1),
    .m_axis_simple_tready(m_tready), .m_axis_simple_tlast(m_tlast1),
    .imag_err(ierr1), .imag_err_clr(clr), .beat_count(bc1)
  );

  logic [127:0] pass_exp0 [4] = '{
    128'h1007_1006_1005_1004_1003_1002_1001_1000,
    128'h1107_1106_1105_1104_1103_1102_1101_1100,
    128'h1207_1206_1205_1204_1203_1202_1201_1200,
    128'h1307_1306_1305_1304_1303_1302_1301_1300};
  logic [15:0]  pass_exp1 [4] = '{16'h0100, 16'h0110, 16'h0120, 16'h0130};
  logic [15:0]  rnd_in    [5] = '{16'h7FFF, 16'h8000, 16'hFFF8, 16'hFFF7, 16'h0008};
  logic [15:0]  rnd_exp   [5] = '{16'h0800, 16'hF800, 16'h0000, 16'hFFFF, 16'h0001};
  int           bp_in     [9] = '{0, 1, 2, 2, 2, 2, 3, 4, -1};
  logic         bp_rdy    [9] = '{1, 0, 0, 0, 1, 1, 1, 1, 1};
  int           bp_out    [9] = '{0, 0, 0, 0, 1, 2, 3, 4, -1};
  logic         bp_srdy   [9] = '{1, 0, 0, 0, 1, 1, 1, 1, 1};

  function automatic logic [255:0] mk_beat(input logic [15:0] re_base, input logic [15:0] re_step,
                                           input logic [15:0] im3);
    logic [255:0] b;
    b = '0;
    for (int c = 0; c < 8; c++) begin
      b[c*32 +: 16]      = re_base + re_step * 16'(c);
      b[c*32 + 16 +: 16] = (c == 3) ? im3 : 16'h0000;
    end
    return b;
  endfunction

  function automatic logic [127:0] ramp(input logic [15:0] base);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 8; c++) r[c*16 +: 16] = base + 16'(c);
    return r;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    aresetn  = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    clr      = 1'b0;
    #1;
    chk("rst_mvalid", 128'(m_tvalid0), 128'd0);
    chk("rst_sready", 128'(s_tready0), 128'd0);
    chk("rst_mdata",  m_tdata0, 128'd0);
    chk("rst_mlast",  128'(m_tlast0), 128'd0);
    chk("rst_ierr",   128'(ierr0), 128'd0);
    chk("rst_count",  128'(bc0), 128'd0);
    tick();
    tick();
    aresetn = 1'b1;
    chk("rel_sready_low", 128'(s_tready0), 128'd0);
    tick();
    chk("rel_sready_high", 128'(s_tready0), 128'd1);
    chk("rel_mvalid", 128'(m_tvalid0), 128'd0);

    // Passthrough, sink always ready
    for (int k = 0; k < 4; k++) begin
      s_tdata  = mk_beat(16'h1000 + 16'h0100 * 16'(k), 16'h0001, 16'h0000);
      s_tvalid = 1'b1;
      s_tlast  = (k == 3);
      tick();
      chk($sformatf("pass_mvalid_%0d", k), 128'(m_tvalid0), 128'd1);
      chk($sformatf("pass_d0_%0d", k), m_tdata0, pass_exp0[k]);
      chk($sformatf("pass_d1_%0d", k), m_tdata1, {8{pass_exp1[k]}});
      chk($sformatf("pass_last_%0d", k), 128'(m_tlast0), 128'(k == 3));
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    tick();
    chk("pass_drained", 128'(m_tvalid0), 128'd0);
    chk("pass_count",   128'(bc0), 128'd4);
    chk("pass_ierr",    128'(ierr0), 128'd0);

    // Rounding shift on dut1, raw passthrough on dut0
    for (int k = 0; k < 5; k++) begin
      s_tdata  = mk_beat(rnd_in[k], 16'h0000, 16'h0000);
      s_tvalid = 1'b1;
      tick();
      chk($sformatf("rnd_d1_%0d", k), m_tdata1, {8{rnd_exp[k]}});
      chk($sformatf("rnd_d0_%0d", k), m_tdata0, {8{rnd_in[k]}});
    end
    s_tvalid = 1'b0;
    tick();
    chk("rnd_count", 128'(bc1), 128'd9);

    // Backpressure: sink stalls for three cycles mid-stream
    for (int n = 0; n < 9; n++) begin
      s_tvalid = (bp_in[n] >= 0);
      s_tdata  = (bp_in[n] >= 0) ? mk_beat(16'h2000 + 16'h0100 * 16'(bp_in[n]), 16'h0001, 16'h0000) : '0;
      s_tlast  = (bp_in[n] == 4);
      m_tready = bp_rdy[n];
      tick();
      chk($sformatf("bp_sready_%0d", n), 128'(s_tready0), 128'(bp_srdy[n]));
      chk($sformatf("bp_mvalid_%0d", n), 128'(m_tvalid0), 128'(bp_out[n] >= 0));
      if (bp_out[n] >= 0) begin
        chk($sformatf("bp_d0_%0d", n), m_tdata0, ramp(16'h2000 + 16'h0100 * 16'(bp_out[n])));
        chk($sformatf("bp_d1_%0d", n), m_tdata1, {8{16'h0200 + 16'h0010 * 16'(bp_out[n])}});
        chk($sformatf("bp_last_%0d", n), 128'(m_tlast0), 128'(bp_out[n] == 4));
      end
    end
    s_tlast = 1'b0;
    chk("bp_count", 128'(bc0), 128'd14);

    // Imaginary residual checks (dut0 tolerance 2, dut1 tolerance 0)
    s_tdata  = mk_beat(16'h0010, 16'h0000, 16'hFFFD);
    s_tvalid = 1'b1;
    tick();
    chk("im_m3_d0", 128'(ierr0), 128'd1);
    chk("im_m3_d1", 128'(ierr1), 128'd1);
    s_tvalid = 1'b0;
    clr      = 1'b1;
    tick();
    clr = 1'b0;
    chk("im_clr1", 128'(ierr0), 128'd0);

    s_tdata  = mk_beat(16'h0010, 16'h0000, 16'h0002);
    s_tvalid = 1'b1;
    tick();
    chk("im_tol_d0", 128'(ierr0), 128'd0);
    chk("im_tol_d1", 128'(ierr1), 128'd1);
    s_tvalid = 1'b0;
    clr      = 1'b1;
    tick();
    clr = 1'b0;
    chk("im_clr2", 128'(ierr1), 128'd0);

    s_tdata  = mk_beat(16'h0010, 16'h0000, 16'h8000);
    s_tvalid = 1'b1;
    tick();
    chk("im_min_d0", 128'(ierr0), 128'd1);
    s_tvalid = 1'b0;
    tick();
    chk("im_sticky", 128'(ierr0), 128'd1);

    s_tdata  = mk_beat(16'h0010, 16'h0000, 16'hFFFD);
    s_tvalid = 1'b1;
    clr      = 1'b1;
    tick();
    chk("im_set_wins", 128'(ierr0), 128'd1);
    s_tvalid = 1'b0;
    tick();
    clr = 1'b0;
    chk("im_clr3", 128'(ierr0), 128'd0);
    chk("im_count", 128'(bc0), 128'd18);

    // Reset while FULL
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = mk_beat(16'h2000, 16'h0001, 16'h0000);
    tick();
    s_tdata = mk_beat(16'h2100, 16'h0001, 16'h0000);
    tick();
    chk("full_sready", 128'(s_tready0), 128'd0);
    chk("full_mvalid", 128'(m_tvalid0), 128'd1);
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    #1;
    chk("mrst_mvalid", 128'(m_tvalid0), 128'd0);
    chk("mrst_sready", 128'(s_tready0), 128'd0);
    chk("mrst_count",  128'(bc0), 128'd0);
    chk("mrst_mdata",  m_tdata0, 128'd0);
    tick();
    aresetn  = 1'b1;
    m_tready = 1'b1;
    chk("mrel_sready_low", 128'(s_tready0), 128'd0);
    tick();
    chk("mrel_sready_high", 128'(s_tready0), 128'd1);
    chk("mrel_mvalid", 128'(m_tvalid0), 128'd0);
    s_tdata  = mk_beat(16'h3000, 16'h0001, 16'h0000);
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
    chk("mrel_first_valid", 128'(m_tvalid0), 128'd1);
    chk("mrel_first_data",  m_tdata0, ramp(16'h3000));
    tick();
    chk("mrel_count", 128'(bc0), 128'd1);
    chk("mrel_drained", 128'(m_tvalid0), 128'd0);

    // Counter wrap from a forced all-ones value
    force dut0.beat_count_q = 32'hFFFF_FFFF;
    #1;
    release dut0.beat_count_q;
    s_tdata  = mk_beat(16'h4000, 16'h0001, 16'h0000);
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
    chk("wrap_hold", 128'(bc0), 128'hFFFF_FFFF);
    tick();
    chk("wrap_zero", 128'(bc0), 128'd0);
    chk("wrap_other", 128'(bc1), 128'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
